svc_rv_dcache_arb: RTL and testbench
====================================

# svc_rv_dcache_arb

Two-requester arbiter that shares one data cache valid/ready port between two independent masters. Port 0 is the CPU dmem cache bridge; port 1 is a secondary master such as a debug or DMA engine. The block sits between those masters and the cache's `rd_*`/`wr_*` interface. It serializes transactions: at most one is in flight at a time, and each read stays owned until its `rd_data_valid` returns. It routes read responses back only to the owning requester.

## Interface
- `AW`, 32, address width of all ports
- `DW`, 32, data width; strobe width is `DW/8`
- `clk`  in  1  clock; all logic on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `s0_rd_valid`/`s1_rd_valid`  in  1  read request
- `s0_rd_ready`/`s1_rd_ready`  out  1  read request accepted
- `s0_rd_addr`/`s1_rd_addr`  in  AW  read address
- `s0_rd_data`/`s1_rd_data`  out  DW  read data (broadcast of `c_rd_data`)
- `s0_rd_data_valid`/`s1_rd_data_valid`  out  1  read response strobe, owner only
- `s0_wr_valid`/`s1_wr_valid`  in  1  write request
- `s0_wr_ready`/`s1_wr_ready`  out  1  write accepted
- `s0_wr_addr`/`s1_wr_addr`  in  AW  write address
- `s0_wr_data`/`s1_wr_data`  in  DW  write data
- `s0_wr_strb`/`s1_wr_strb`  in  DW/8  byte strobes
- `c_rd_valid`, `c_rd_addr`  out  1, AW  cache read request
- `c_rd_ready`  in  1  cache read request accepted
- `c_rd_data`  in  DW  cache read data
- `c_rd_data_valid`  in  1  cache read response strobe
- `c_wr_valid`, `c_wr_addr`, `c_wr_data`, `c_wr_strb`  out  1, AW, DW, DW/8  cache write request
- `c_wr_ready`  in  1  cache write accepted

## Operation
- State machine with states `IDLE`, `WR`, `RD_REQ`, `RD_WAIT`. A registered `owner` bit names the granted requester.
- **IDLE:**
  - Build the candidate set; requester n is a candidate if `sn_wr_valid | sn_rd_valid`.
  - Pick the owner by round-robin: the requester other than `last` wins a tie.
  - Within the owner, a write has priority over a read. This preserves store→load order.
  - Register `owner` and `last`, then go to `WR` or `RD_REQ`.
- **WR:**
  - `c_wr_*` = owner's `wr_*`; `c_wr_valid` = owner's `wr_valid`.
  - Owner's `wr_ready` = `c_wr_ready`.
  - On handshake, return to `IDLE`.
- **RD_REQ:**
  - `c_rd_*` = owner's `rd_*`; owner's `rd_ready` = `c_rd_ready`.
  - On handshake, go to `RD_WAIT`.
- **RD_WAIT:**
  - No cache valid is asserted.
  - `c_rd_data_valid` is forwarded to the owner only, and the state returns to `IDLE`.
- The non-owner's ready and `rd_data_valid` signals are held at 0 in every state.
- Requesters must hold valid, address, data and strobe stable until ready. If the owner deasserts valid before ready, that is a protocol violation; the arbiter keeps waiting in the same state.
- A `c_rd_data_valid` arriving in `IDLE`, `WR` or `RD_REQ` is ignored and not forwarded.
- Reset mid-transaction:
  - State goes to `IDLE`, `owner` = 0, `last` = 1, so s0 wins the first tie.
  - Any in-flight response is dropped; the cache is reset together with this block.

## Timing
- All outputs are 0 during reset, except `sN_rd_data`, which follows `c_rd_data`.
- Cache-side valids are combinational from the state register and the owner's inputs. There is no combinational path from a cache ready to any cache valid.
- Arbitration latency is 1 cycle: a request first seen in `IDLE` reaches `c_*_valid` on the next cycle.
- Write cost: 2 cycles minimum (arbitrate + handshake).
- Read cost: 2 cycles + cache response latency, plus 1 `IDLE` cycle before the next grant.
- Back-to-back requests from the same requester alternate with a waiting other requester under round-robin.

## Configuration
- Macro: `SVC_RV_DCACHE_ARB_FIXED_PRIO_EN`.
- Defined: s0 always wins in `IDLE` and `last` is not used. This gives the CPU strict priority; s1 can starve.
- Undefined: 2-way round-robin as described above. No requester waits more than one foreign transaction.

## Structure
- Package `svc_rv_dcache_arb_pkg` holds:
  - `typedef enum logic [1:0] {IDLE, WR, RD_REQ, RD_WAIT} arb_state_t`
  - localparams `OWNER_S0 = 1'b0` and `OWNER_S1 = 1'b1`
- Sub-module `svc_arb_rr2`: combinational 2-way grant from `req[1:0]` and `last`. It also honours the fixed-priority macro.
- The top level holds the FSM, the `owner`/`last` registers and the datapath muxes.

## Test plan
- s0 write `0x100`/`0xDEADBEEF`/`0xF` with `c_wr_ready` = 1 → `c_wr_valid` cycle 1, `s0_wr_ready` cycle 1, `IDLE` cycle 2, s1 signals untouched.
- s0 read `0x200`, cache responds 3 cycles after handshake with `0x12345678` → only `s0_rd_data_valid` pulses, data matches, `s1_rd_data_valid` stays 0.
- s0 and s1 both write continuously, round-robin build → grants alternate s0, s1, s0, s1; fixed-prio build → s1 never granted while s0 is valid.
- s0 asserts write and read together → write to `0x40` issued before read of `0x40`; the read returns the new data.
- `c_rd_ready` held 0 for 5 cycles during s1 read → `c_rd_valid`/`c_rd_addr` stable, s0 request blocked, s0 granted after s1 response.
- Assert `rst` while in `RD_WAIT`, then deliver `c_rd_data_valid` → no `sN_rd_data_valid` pulse; a new s1-only request is granted 1 cycle after `rst` deasserts.

Source files
------------

// File: rtl/svc_rv_dcache_arb_pkg.sv
// Shared types and owner encodings for the two-requester data cache arbiter.
package svc_rv_dcache_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WR,
        RD_REQ,
        RD_WAIT
    } arb_state_t;

    localparam logic OWNER_S0 = 1'b0;
    localparam logic OWNER_S1 = 1'b1;

endpackage

// File: rtl/svc_arb_rr2.sv
// Combinational 2-way grant. Round-robin on last winner by default;
// SVC_RV_DCACHE_ARB_FIXED_PRIO_EN makes requester 0 always win.
module svc_arb_rr2
    import svc_rv_dcache_arb_pkg::*;
(
    input  logic [1:0] i_req,
    input  logic       i_last,
    output logic       o_grant
);

`ifdef SVC_RV_DCACHE_ARB_FIXED_PRIO_EN
    logic w_unused_last;
    assign w_unused_last = i_last;

    always_comb begin
        if (i_req[0]) begin
            o_grant = OWNER_S0;
        end else if (i_req[1]) begin
            o_grant = OWNER_S1;
        end else begin
            o_grant = OWNER_S0;
        end
    end
`else
    always_comb begin
        // On a tie the requester that did not win last time takes the grant.
        if (i_req == 2'b11) begin
            o_grant = ~i_last;
        end else if (i_req[1]) begin
            o_grant = OWNER_S1;
        end else begin
            o_grant = OWNER_S0;
        end
    end
`endif

endmodule

// File: rtl/svc_rv_dcache_arb.sv
// Shares one data cache rd/wr port between a CPU (s0) and a secondary master (s1).
// Define SVC_RV_DCACHE_ARB_FIXED_PRIO_EN for strict s0 priority instead of round-robin.
module svc_rv_dcache_arb
    import svc_rv_dcache_arb_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic            clk,
    input  logic            rst,

    input  logic            s0_rd_valid,
    output logic            s0_rd_ready,
    input  logic [AW-1:0]   s0_rd_addr,
    output logic [DW-1:0]   s0_rd_data,
    output logic            s0_rd_data_valid,
    input  logic            s0_wr_valid,
    output logic            s0_wr_ready,
    input  logic [AW-1:0]   s0_wr_addr,
    input  logic [DW-1:0]   s0_wr_data,
    input  logic [DW/8-1:0] s0_wr_strb,

    input  logic            s1_rd_valid,
    output logic            s1_rd_ready,
    input  logic [AW-1:0]   s1_rd_addr,
    output logic [DW-1:0]   s1_rd_data,
    output logic            s1_rd_data_valid,
    input  logic            s1_wr_valid,
    output logic            s1_wr_ready,
    input  logic [AW-1:0]   s1_wr_addr,
    input  logic [DW-1:0]   s1_wr_data,
    input  logic [DW/8-1:0] s1_wr_strb,

    output logic            c_rd_valid,
    output logic [AW-1:0]   c_rd_addr,
    input  logic            c_rd_ready,
    input  logic [DW-1:0]   c_rd_data,
    input  logic            c_rd_data_valid,
    output logic            c_wr_valid,
    output logic [AW-1:0]   c_wr_addr,
    output logic [DW-1:0]   c_wr_data,
    output logic [DW/8-1:0] c_wr_strb,
    input  logic            c_wr_ready
);

    arb_state_t r_state;
    logic       r_owner;
    logic       r_last;

    logic [1:0] w_req;
    logic       w_grant;
    logic       w_grant_wr;
    logic       w_wr_ready;
    logic       w_rd_ready;
    logic       w_rd_dv;

    assign w_req      = {s1_wr_valid | s1_rd_valid, s0_wr_valid | s0_rd_valid};
    // Writes win within the granted requester so a store is never overtaken by its load.
    assign w_grant_wr = (w_grant == OWNER_S1) ? s1_wr_valid : s0_wr_valid;

    svc_arb_rr2 u_arb (
        .i_req   (w_req),
        .i_last  (r_last),
        .o_grant (w_grant)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_owner <= OWNER_S0;
            r_last  <= OWNER_S1;
        end else begin
            case (r_state)
                IDLE: begin
                    if (|w_req) begin
                        r_owner <= w_grant;
                        r_last  <= w_grant;
                        r_state <= w_grant_wr ? WR : RD_REQ;
                    end
                end
                WR: if (c_wr_valid && c_wr_ready) r_state <= IDLE;
                RD_REQ: if (c_rd_valid && c_rd_ready) r_state <= RD_WAIT;
                RD_WAIT: if (c_rd_data_valid) r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    always_comb begin
        c_wr_valid = 1'b0;
        c_wr_addr  = '0;
        c_wr_data  = '0;
        c_wr_strb  = '0;
        c_rd_valid = 1'b0;
        c_rd_addr  = '0;
        w_wr_ready = 1'b0;
        w_rd_ready = 1'b0;
        w_rd_dv    = 1'b0;
        case (r_state)
            WR: begin
                c_wr_valid = (r_owner == OWNER_S1) ? s1_wr_valid : s0_wr_valid;
                c_wr_addr  = (r_owner == OWNER_S1) ? s1_wr_addr  : s0_wr_addr;
                c_wr_data  = (r_owner == OWNER_S1) ? s1_wr_data  : s0_wr_data;
                c_wr_strb  = (r_owner == OWNER_S1) ? s1_wr_strb  : s0_wr_strb;
                w_wr_ready = c_wr_ready;
            end
            RD_REQ: begin
                c_rd_valid = (r_owner == OWNER_S1) ? s1_rd_valid : s0_rd_valid;
                c_rd_addr  = (r_owner == OWNER_S1) ? s1_rd_addr  : s0_rd_addr;
                w_rd_ready = c_rd_ready;
            end
            RD_WAIT: w_rd_dv = c_rd_data_valid;
            default: ;
        endcase
    end

    assign s0_wr_ready      = w_wr_ready & (r_owner == OWNER_S0);
    assign s1_wr_ready      = w_wr_ready & (r_owner == OWNER_S1);
    assign s0_rd_ready      = w_rd_ready & (r_owner == OWNER_S0);
    assign s1_rd_ready      = w_rd_ready & (r_owner == OWNER_S1);
    assign s0_rd_data_valid = w_rd_dv & (r_owner == OWNER_S0);
    assign s1_rd_data_valid = w_rd_dv & (r_owner == OWNER_S1);
    assign s0_rd_data       = c_rd_data;
    assign s1_rd_data       = c_rd_data;

endmodule

// File: tb/tb_svc_rv_dcache_arb.sv
// Self-checking bench: directed scenarios with literal expectations, then random
// traffic checked every cycle against a transaction-level model of the arbiter.
module tb_svc_rv_dcache_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic        wv[2], rv[2];
    logic [31:0] wa[2], wd[2], ra[2];
    logic [3:0]  ws[2];
    logic        wr_rdy[2], rd_rdy[2], rdv[2];
    logic [31:0] rdd[2];
    logic        c_rd_valid, c_rd_ready, c_rd_data_valid, c_wr_valid, c_wr_ready;
    logic [31:0] c_rd_addr, c_rd_data, c_wr_addr, c_wr_data;
    logic [3:0]  c_wr_strb;

    int checks = 0;
    int errors = 0;

    // Model: one transaction record (busy, owner, kind, request-accepted) plus last winner.
    logic m_busy, m_own, m_wr, m_acc, m_last;
    logic hs_w[2], hs_r[2];
    logic c_pend;
    int   c_cnt;

    always #5 clk = ~clk;

    svc_rv_dcache_arb dut (
        .clk              (clk),
        .rst              (rst),
        .s0_rd_valid      (rv[0]),
        .s0_rd_ready      (rd_rdy[0]),
        .s0_rd_addr       (ra[0]),
        .s0_rd_data       (rdd[0]),
        .s0_rd_data_valid (rdv[0]),
        .s0_wr_valid      (wv[0]),
        .s0_wr_ready      (wr_rdy[0]),
        .s0_wr_addr       (wa[0]),
        .s0_wr_data       (wd[0]),
        .s0_wr_strb       (ws[0]),
        .s1_rd_valid      (rv[1]),
        .s1_rd_ready      (rd_rdy[1]),
        .s1_rd_addr       (ra[1]),
        .s1_rd_data       (rdd[1]),
        .s1_rd_data_valid (rdv[1]),
        .s1_wr_valid      (wv[1]),
        .s1_wr_ready      (wr_rdy[1]),
        .s1_wr_addr       (wa[1]),
        .s1_wr_data       (wd[1]),
        .s1_wr_strb       (ws[1]),
        .c_rd_valid       (c_rd_valid),
        .c_rd_addr        (c_rd_addr),
        .c_rd_ready       (c_rd_ready),
        .c_rd_data        (c_rd_data),
        .c_rd_data_valid  (c_rd_data_valid),
        .c_wr_valid       (c_wr_valid),
        .c_wr_addr        (c_wr_addr),
        .c_wr_data        (c_wr_data),
        .c_wr_strb        (c_wr_strb),
        .c_wr_ready       (c_wr_ready)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare every DUT output against the model for the current cycle.
    task automatic mcheck();
        logic o, wphase, rphase, wait_rsp;
        if (rst) begin
            m_busy = 0; m_own = 0; m_wr = 0; m_acc = 0; m_last = 1;
            chk("m_rst_c_wr_addr", c_wr_addr, 0);
            chk("m_rst_c_wr_data", c_wr_data, 0);
            chk("m_rst_c_wr_strb", {28'b0, c_wr_strb}, 0);
            chk("m_rst_c_rd_addr", c_rd_addr, 0);
        end
        o        = m_own;
        wphase   = m_busy && m_wr;
        rphase   = m_busy && !m_wr && !m_acc;
        wait_rsp = m_busy && !m_wr && m_acc;
        for (int n = 0; n < 2; n++) begin
            chk($sformatf("m_s%0d_wr_ready", n), {31'b0, wr_rdy[n]},
                {31'b0, wphase && o == 1'(n) && c_wr_ready});
            chk($sformatf("m_s%0d_rd_ready", n), {31'b0, rd_rdy[n]},
                {31'b0, rphase && o == 1'(n) && c_rd_ready});
            chk($sformatf("m_s%0d_rd_data_valid", n), {31'b0, rdv[n]},
                {31'b0, wait_rsp && o == 1'(n) && c_rd_data_valid});
            chk($sformatf("m_s%0d_rd_data", n), rdd[n], c_rd_data);
            hs_w[n] = wphase && o == 1'(n) && c_wr_ready && wv[n];
            hs_r[n] = rphase && o == 1'(n) && c_rd_ready && rv[n];
        end
        chk("m_c_wr_valid", {31'b0, c_wr_valid}, {31'b0, wphase && wv[o]});
        chk("m_c_rd_valid", {31'b0, c_rd_valid}, {31'b0, rphase && rv[o]});
        if (wphase && wv[o]) begin
            chk("m_c_wr_addr", c_wr_addr, wa[o]);
            chk("m_c_wr_data", c_wr_data, wd[o]);
            chk("m_c_wr_strb", {28'b0, c_wr_strb}, {28'b0, ws[o]});
        end
        if (rphase && rv[o]) chk("m_c_rd_addr", c_rd_addr, ra[o]);
    endtask

    task automatic madvance();
        logic q0, q1, win;
        if (rst) return;
        if (!m_busy) begin
            q0 = wv[0] | rv[0];
            q1 = wv[1] | rv[1];
            if (q0 | q1) begin
`ifdef SVC_RV_DCACHE_ARB_FIXED_PRIO_EN
                win = !q0;
`else
                win = (q0 && q1) ? !m_last : q1;
`endif
                m_busy = 1; m_own = win; m_last = win; m_wr = wv[win]; m_acc = 0;
            end
        end else if (m_wr) begin
            if (wv[m_own] && c_wr_ready) m_busy = 0;
        end else if (!m_acc) begin
            if (rv[m_own] && c_rd_ready) m_acc = 1;
        end else if (c_rd_data_valid) begin
            m_busy = 0;
        end
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic fin();
        mcheck();
        madvance();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        for (int n = 0; n < 2; n++) begin
            wv[n] = 0; rv[n] = 0; wa[n] = 0; wd[n] = 0; ra[n] = 0; ws[n] = 0;
        end
        c_rd_ready = 0; c_rd_data_valid = 0; c_wr_ready = 0; c_rd_data = 0;
    endtask

    logic [31:0] mem40;
    logic [31:0] gexp[4];
    int gi;

    initial begin
        idle_inputs();
        rst = 1;
        m_busy = 0; m_own = 0; m_wr = 0; m_acc = 0; m_last = 1;
        c_pend = 0; c_cnt = 0;
        @(negedge clk);
        c_rd_data = 32'hCAFEF00D;
        c_wr_ready = 1; c_rd_ready = 1;
        settle();
        chk("rst_c_wr_valid", {31'b0, c_wr_valid}, 0);
        chk("rst_c_rd_valid", {31'b0, c_rd_valid}, 0);
        chk("rst_s0_wr_ready", {31'b0, wr_rdy[0]}, 0);
        chk("rst_s0_rd_data", rdd[0], 32'hCAFEF00D);
        fin();
        rst = 0;

        // s0 write: valid on cycle 1, back to idle on cycle 2
        wv[0] = 1; wa[0] = 32'h100; wd[0] = 32'hDEADBEEF; ws[0] = 4'hF;
        settle(); chk("t1_c0_wr_valid", {31'b0, c_wr_valid}, 0); fin();
        settle();
        chk("t1_c1_wr_valid", {31'b0, c_wr_valid}, 1);
        chk("t1_c1_wr_addr", c_wr_addr, 32'h100);
        chk("t1_c1_wr_data", c_wr_data, 32'hDEADBEEF);
        chk("t1_c1_wr_strb", {28'b0, c_wr_strb}, 32'hF);
        chk("t1_c1_s0_wr_ready", {31'b0, wr_rdy[0]}, 1);
        chk("t1_c1_s1_wr_ready", {31'b0, wr_rdy[1]}, 0);
        fin();
        wv[0] = 0;
        settle(); chk("t1_c2_wr_valid", {31'b0, c_wr_valid}, 0); fin();

        // s0 read, response three cycles after the handshake
        rv[0] = 1; ra[0] = 32'h200;
        settle(); fin();
        settle();
        chk("t2_rd_valid", {31'b0, c_rd_valid}, 1);
        chk("t2_rd_addr", c_rd_addr, 32'h200);
        chk("t2_s0_rd_ready", {31'b0, rd_rdy[0]}, 1);
        fin();
        rv[0] = 0;
        for (int i = 0; i < 2; i++) begin
            settle(); chk("t2_wait_dv", {31'b0, rdv[0]}, 0); fin();
        end
        c_rd_data_valid = 1; c_rd_data = 32'h12345678;
        settle();
        chk("t2_s0_dv", {31'b0, rdv[0]}, 1);
        chk("t2_s1_dv", {31'b0, rdv[1]}, 0);
        chk("t2_s0_data", rdd[0], 32'h12345678);
        fin();
        c_rd_data_valid = 0;
        settle(); fin();

        // both write continuously: last winner is s0, so s1 is next under round-robin
`ifdef SVC_RV_DCACHE_ARB_FIXED_PRIO_EN
        gexp[0] = 0; gexp[1] = 0; gexp[2] = 0; gexp[3] = 0;
`else
        gexp[0] = 1; gexp[1] = 0; gexp[2] = 1; gexp[3] = 0;
`endif
        wv[0] = 1; wa[0] = 32'h10; wd[0] = 32'h1;
        wv[1] = 1; wa[1] = 32'h20; wd[1] = 32'h2; ws[1] = 4'h3;
        gi = 0;
        for (int i = 0; i < 20 && gi < 4; i++) begin
            settle();
            if (wr_rdy[0] | wr_rdy[1]) begin
                chk($sformatf("t3_grant%0d", gi), {31'b0, wr_rdy[1]}, gexp[gi]);
                gi++;
            end
            fin();
        end
        chk("t3_grant_count", gi, 4);
        wv[0] = 0; wv[1] = 0;
        settle(); fin();

        // s0 write and read to the same address together: write first
        wv[0] = 1; wa[0] = 32'h40; wd[0] = 32'hA5A5A5A5; ws[0] = 4'hF;
        rv[0] = 1; ra[0] = 32'h40; mem40 = 0;
        settle(); fin();
        settle();
        chk("t4_wr_first", {31'b0, c_wr_valid}, 1);
        chk("t4_no_rd", {31'b0, c_rd_valid}, 0);
        chk("t4_wr_addr", c_wr_addr, 32'h40);
        if (c_wr_valid && c_wr_ready) mem40 = c_wr_data;
        fin();
        wv[0] = 0;
        settle(); chk("t4_idle_gap", {31'b0, c_rd_valid}, 0); fin();
        settle();
        chk("t4_rd_valid", {31'b0, c_rd_valid}, 1);
        chk("t4_rd_addr", c_rd_addr, 32'h40);
        fin();
        rv[0] = 0; c_rd_data_valid = 1; c_rd_data = mem40;
        settle();
        chk("t4_dv", {31'b0, rdv[0]}, 1);
        chk("t4_new_data", rdd[0], 32'hA5A5A5A5);
        fin();
        c_rd_data_valid = 0;

        // s1 read stalled by c_rd_ready=0 while s0 waits to write
        c_rd_ready = 0; rv[1] = 1; ra[1] = 32'h300;
        settle(); fin();
        wv[0] = 1; wa[0] = 32'h44; wd[0] = 32'h77; ws[0] = 4'h1;
        for (int i = 0; i < 5; i++) begin
            settle();
            chk("t5_rd_valid_hold", {31'b0, c_rd_valid}, 1);
            chk("t5_rd_addr_hold", c_rd_addr, 32'h300);
            chk("t5_s0_blocked", {31'b0, wr_rdy[0] | c_wr_valid}, 0);
            fin();
        end
        c_rd_ready = 1;
        settle(); chk("t5_s1_rd_ready", {31'b0, rd_rdy[1]}, 1); fin();
        rv[1] = 0; c_rd_data_valid = 1; c_rd_data = 32'h55;
        settle();
        chk("t5_s1_dv", {31'b0, rdv[1]}, 1);
        chk("t5_s0_dv", {31'b0, rdv[0]}, 0);
        fin();
        c_rd_data_valid = 0;
        settle(); chk("t5_idle", {31'b0, c_wr_valid}, 0); fin();
        settle();
        chk("t5_s0_granted", {31'b0, c_wr_valid}, 1);
        chk("t5_s0_wr_ready", {31'b0, wr_rdy[0]}, 1);
        fin();
        wv[0] = 0;
        settle(); fin();

        // reset while waiting for a read response
        rv[1] = 1; ra[1] = 32'h500;
        settle(); fin();
        settle(); fin();
        rv[1] = 0;
        settle(); fin();
        rst = 1;
        settle();
        chk("t6_rst_rd_valid", {31'b0, c_rd_valid}, 0);
        chk("t6_rst_s1_dv", {31'b0, rdv[1]}, 0);
        fin();
        settle(); fin();
        rst = 0; rv[1] = 1; ra[1] = 32'h600; c_rd_data_valid = 1;
        settle();
        chk("t6_drop_s0_dv", {31'b0, rdv[0]}, 0);
        chk("t6_drop_s1_dv", {31'b0, rdv[1]}, 0);
        chk("t6_idle", {31'b0, c_rd_valid}, 0);
        fin();
        c_rd_data_valid = 0;
        settle();
        chk("t6_s1_granted", {31'b0, c_rd_valid}, 1);
        chk("t6_s1_addr", c_rd_addr, 32'h600);
        fin();
        rv[1] = 0; c_rd_data_valid = 1;
        settle(); fin();
        c_rd_data_valid = 0;
        settle(); fin();

        // random traffic against the model
        for (int n = 0; n < 2; n++) begin
            hs_w[n] = 0; hs_r[n] = 0;
        end
        c_pend = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int n = 0; n < 2; n++) begin
                if (hs_w[n]) wv[n] = 0;
                if (hs_r[n]) rv[n] = 0;
                if (!wv[n] && $urandom_range(3) == 0) begin
                    wv[n] = 1; wa[n] = $urandom & 32'hFFC; wd[n] = $urandom;
                    ws[n] = 4'($urandom);
                end
                if (!rv[n] && $urandom_range(3) == 0) begin
                    rv[n] = 1; ra[n] = $urandom & 32'hFFC;
                end
            end
            if (hs_r[0] | hs_r[1]) begin
                c_pend = 1; c_cnt = $urandom_range(3);
            end
            if (c_pend) begin
                if (c_cnt == 0) begin
                    c_rd_data_valid = 1; c_pend = 0;
                end else begin
                    c_rd_data_valid = 0; c_cnt--;
                end
            end else begin
                c_rd_data_valid = ($urandom_range(7) == 0);
            end
            c_rd_data  = $urandom;
            c_wr_ready = ($urandom_range(2) != 0);
            c_rd_ready = ($urandom_range(2) != 0);
            settle();
            fin();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
